axis_sample_fifo: RTL and testbench

AXIS_SAMPLE_FIFO -- requirements
Module: axis_sample_fifo

---
 rtl/axis_sample_fifo.sv | 126 ++++++++++++
 tb/tb_axis_sample_fifo.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sample_fifo.sv
// rtl/axis_sample_fifo.sv - stereo sample FIFO with pair-aware admission and drop statistics
// Optional drop statistics enabled by defining AXIS_SAMPLE_FIFO_STATS_EN.
module axis_sample_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      s_axis_data,
  input  logic                       s_axis_valid,
  output logic                       s_axis_ready,
  input  logic                       s_axis_last,
  output logic [DATA_WIDTH-1:0]      m_axis_data,
  output logic                       m_axis_valid,
  input  logic                       m_axis_ready,
  output logic                       m_axis_last,
  output logic [$clog2(DEPTH):0]     o_level,
  input  logic                       i_clear_stats,
  output logic                       o_overflow,
  output logic [15:0]                o_drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);
  localparam logic [LW-1:0] TWO_L   = LW'(2);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       level;
  logic [LW-1:0]       free_cnt;
  logic                drop_pair;
  logic                drop_pair_next;
  logic                ready_q;
  logic                wr_en;
  logic                drop;
  logic                pop;

  assign s_axis_ready = ready_q;
  assign o_level      = level;
  assign free_cnt     = DEPTH_L - level;
  assign m_axis_valid = (level != '0);
  assign pop          = m_axis_valid && m_axis_ready;
  // Gate the head word so the outputs read as zero whenever nothing is stored.
  assign m_axis_data  = m_axis_valid ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
  assign m_axis_last  = m_axis_valid ? mem[rd_ptr][DATA_WIDTH] : 1'b0;

  // Admission uses the start-of-cycle level; a left sample needs room for its right partner.
  always_comb begin
    wr_en          = 1'b0;
    drop           = 1'b0;
    drop_pair_next = drop_pair;
    if (s_axis_valid && ready_q) begin
      if (!s_axis_last) begin
        if (free_cnt >= TWO_L) begin
          wr_en          = 1'b1;
          drop_pair_next = 1'b0;
        end else begin
          drop           = 1'b1;
          drop_pair_next = 1'b1;
        end
      end else if (drop_pair) begin
        drop           = 1'b1;
        drop_pair_next = 1'b0;
      end else if (free_cnt >= ONE_L) begin
        wr_en = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {s_axis_last, s_axis_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      drop_pair <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      ready_q   <= 1'b1;
      drop_pair <= drop_pair_next;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   level <= level + ONE_L;
        2'b01:   level <= level - ONE_L;
        default: level <= level;
      endcase
    end
  end

`ifdef AXIS_SAMPLE_FIFO_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (i_clear_stats) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (o_drop_count != 16'hFFFF) begin
        o_drop_count <= o_drop_count + 16'd1;
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats = i_clear_stats ^ drop;
  assign o_overflow   = 1'b0;
  assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_axis_sample_fifo.sv
// tb/tb_axis_sample_fifo.sv - randomized self-checking bench for axis_sample_fifo against a queue model
module tb_axis_sample_fifo;
  localparam int DW    = 24;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef AXIS_SAMPLE_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int NDROP = STATS ? 70000 : 40;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_axis_data = '0;
  logic          s_axis_valid = 1'b0;
  logic          s_axis_ready;
  logic          s_axis_last = 1'b0;
  logic [DW-1:0] m_axis_data;
  logic          m_axis_valid;
  logic          m_axis_ready = 1'b0;
  logic          m_axis_last;
  logic [LW-1:0] o_level;
  logic          i_clear_stats = 1'b0;
  logic          o_overflow;
  logic [15:0]   o_drop_count;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of {last, data}, pairing flag, readiness and statistics.
  logic [DW:0] mq[$];
  bit          m_dp  = 1'b0;
  bit          m_rdy = 1'b0;
  bit          m_ovf = 1'b0;
  int          m_cnt = 0;

  axis_sample_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_last(s_axis_last),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_last(m_axis_last),
    .o_level(o_level), .i_clear_stats(i_clear_stats),
    .o_overflow(o_overflow), .o_drop_count(o_drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_data();
    return (mq.size() != 0) ? mq[0][DW-1:0] : '0;
  endfunction

  function automatic logic exp_last();
    return (mq.size() != 0) ? mq[0][DW] : 1'b0;
  endfunction

  function automatic logic [15:0] exp_cnt();
    return STATS ? 16'(m_cnt) : 16'd0;
  endfunction

  function automatic logic exp_ovf();
    return STATS ? m_ovf : 1'b0;
  endfunction

  task automatic drive(input bit v, input bit l, input logic [DW-1:0] d, input bit r);
    s_axis_valid = v;
    s_axis_last  = l;
    s_axis_data  = d;
    m_axis_ready = r;
  endtask

  // One clock with the current inputs; the model advances from the admission rules.
  task automatic step();
    int lvl;
    bit wr;
    bit drp;
    lvl = mq.size();
    wr  = 1'b0;
    drp = 1'b0;
    if (s_axis_valid && m_rdy) begin
      if (!s_axis_last) begin
        m_dp = 1'b0;
        if (DEPTH - lvl >= 2) wr = 1'b1;
        else begin drp = 1'b1; m_dp = 1'b1; end
      end else if (m_dp) begin
        drp  = 1'b1;
        m_dp = 1'b0;
      end else if (DEPTH - lvl >= 1) wr = 1'b1;
      else drp = 1'b1;
    end
    if (i_clear_stats) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end else if (drp) begin
      m_ovf = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
    @(posedge clk);
    if (lvl > 0 && m_axis_ready) void'(mq.pop_front());
    if (wr) mq.push_back({s_axis_last, s_axis_data});
    m_rdy = 1'b1;
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_dp  = 1'b0;
    m_rdy = 1'b0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (s_axis_ready !== 1'b0 || m_axis_valid !== 1'b0 || o_level !== '0 || m_axis_data !== '0) begin
      failures++;
      $display("FAIL reset_state: ready=%b valid=%b level=%0d data=%h required 0/0/0/0",
               s_axis_ready, m_axis_valid, o_level, m_axis_data);
    end
    checks++;
    if (o_overflow !== 1'b0 || o_drop_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_stats: ovf=%b cnt=%0d required 0/0", o_overflow, o_drop_count);
    end
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (s_axis_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge: got %b required 0", s_axis_ready);
    end
    step();
    checks++;
    if (s_axis_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_edge: got %b required 1", s_axis_ready);
    end
  endtask

  task automatic test_basic_pair();
    drive(1'b1, 1'b0, 24'h000111, 1'b1);
    step();
    checks++;
    if (m_axis_valid !== 1'b1 || m_axis_data !== 24'h000111 || m_axis_last !== 1'b0 || o_level !== LW'(1)) begin
      failures++;
      $display("FAIL basic_left: valid=%b data=%h last=%b level=%0d required 1/000111/0/1",
               m_axis_valid, m_axis_data, m_axis_last, o_level);
    end
    drive(1'b1, 1'b1, 24'h000222, 1'b1);
    step();
    checks++;
    if (m_axis_valid !== 1'b1 || m_axis_data !== 24'h000222 || m_axis_last !== 1'b1 || o_level !== LW'(1)) begin
      failures++;
      $display("FAIL basic_right: valid=%b data=%h last=%b level=%0d required 1/000222/1/1",
               m_axis_valid, m_axis_data, m_axis_last, o_level);
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    step();
    checks++;
    if (m_axis_valid !== 1'b0 || o_level !== '0) begin
      failures++;
      $display("FAIL basic_drain: valid=%b level=%0d required 0/0", m_axis_valid, o_level);
    end
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) begin
      checks++;
      if (m_axis_valid !== (mq.size() != 0) || m_axis_data !== exp_data() || m_axis_last !== exp_last()) begin
        failures++;
        $display("FAIL drain_word: valid=%b data=%h last=%b required %b/%h/%b",
                 m_axis_valid, m_axis_data, m_axis_last, mq.size() != 0, exp_data(), exp_last());
      end
      step();
    end
  endtask

  task automatic test_fill_and_pair_drop();
    i_clear_stats = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0);
    step();
    i_clear_stats = 1'b0;
    for (int p = 0; p < 8; p++) begin
      drive(1'b1, 1'b0, DW'($urandom), 1'b0); step();
      drive(1'b1, 1'b1, DW'($urandom), 1'b0); step();
    end
    checks++;
    if (o_level !== LW'(16) || o_drop_count !== 16'd0 || o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL fill_16: level=%0d cnt=%0d ovf=%b required 16/0/0", o_level, o_drop_count, o_overflow);
    end
    drive(1'b1, 1'b0, 24'hABCDEF, 1'b0); step();
    drive(1'b1, 1'b1, 24'h123456, 1'b0); step();
    checks++;
    if (o_level !== LW'(16) || o_drop_count !== (STATS ? 16'd2 : 16'd0) || o_overflow !== STATS) begin
      failures++;
      $display("FAIL ninth_pair: level=%0d cnt=%0d ovf=%b required 16/%0d/%b",
               o_level, o_drop_count, o_overflow, STATS ? 2 : 0, STATS);
    end
    drain();
  endtask

  task automatic test_level15();
    for (int p = 0; p < 8; p++) begin
      drive(1'b1, 1'b0, DW'($urandom), 1'b0); step();
      drive(1'b1, 1'b1, DW'($urandom), 1'b0); step();
    end
    drive(1'b0, 1'b0, '0, 1'b1); step();
    drive(1'b1, 1'b0, 24'h0000AA, 1'b0); step();
    checks++;
    if (o_level !== LW'(15)) begin
      failures++;
      $display("FAIL level15_left: level=%0d required 15", o_level);
    end
    drive(1'b1, 1'b1, 24'h0000BB, 1'b0); step();
    checks++;
    if (o_level !== LW'(15) || o_drop_count !== exp_cnt()) begin
      failures++;
      $display("FAIL level15_right: level=%0d cnt=%0d required 15/%0d", o_level, o_drop_count, exp_cnt());
    end
    drain();
  endtask

  task automatic test_full_pop_right();
    for (int p = 0; p < 8; p++) begin
      drive(1'b1, 1'b0, DW'($urandom), 1'b0); step();
      drive(1'b1, 1'b1, DW'($urandom), 1'b0); step();
    end
    drive(1'b1, 1'b1, 24'h0000CC, 1'b1); step();
    checks++;
    if (o_level !== LW'(15) || o_drop_count !== exp_cnt() || m_axis_data !== exp_data()) begin
      failures++;
      $display("FAIL full_pop_right: level=%0d cnt=%0d head=%h required 15/%0d/%h",
               o_level, o_drop_count, m_axis_data, exp_cnt(), exp_data());
    end
    drain();
  endtask

  task automatic test_random();
    bit lst;
    lst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) lst = ~lst;
      drive($urandom_range(0, 9) < 7, lst, DW'($urandom), $urandom_range(0, 9) < 4);
      if (s_axis_valid) lst = ~lst;
      i_clear_stats = ($urandom_range(0, 99) == 0);
      step();
      checks++;
      if (m_axis_valid !== (mq.size() != 0) || m_axis_data !== exp_data() || m_axis_last !== exp_last()
          || o_level !== LW'(mq.size()) || o_drop_count !== exp_cnt() || o_overflow !== exp_ovf()) begin
        failures++;
        $display("FAIL random_cycle %0d: v=%b d=%h l=%b lvl=%0d cnt=%0d ovf=%b required %b/%h/%b/%0d/%0d/%b",
                 i, m_axis_valid, m_axis_data, m_axis_last, o_level, o_drop_count, o_overflow,
                 mq.size() != 0, exp_data(), exp_last(), mq.size(), exp_cnt(), exp_ovf());
      end
    end
    i_clear_stats = 1'b0;
    drain();
  endtask

  task automatic test_reset_midstream();
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, 1'b0, DW'($urandom), 1'b0); step();
      drive(1'b1, 1'b1, DW'($urandom), 1'b0); step();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (o_level !== LW'(6) || m_axis_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: level=%0d valid=%b required 6/1", o_level, m_axis_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (m_axis_valid !== 1'b0 || o_level !== '0 || s_axis_ready !== 1'b0 || m_axis_data !== '0) begin
      failures++;
      $display("FAIL async_reset: valid=%b level=%0d ready=%b data=%h required 0/0/0/0",
               m_axis_valid, o_level, s_axis_ready, m_axis_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    step();
    drive(1'b1, 1'b1, 24'h000333, 1'b0);
    step();
    checks++;
    if (o_level !== LW'(1) || m_axis_data !== 24'h000333 || m_axis_last !== 1'b1) begin
      failures++;
      $display("FAIL first_after_reset: level=%0d data=%h last=%b required 1/000333/1",
               o_level, m_axis_data, m_axis_last);
    end
    drain();
  endtask

  task automatic test_stats();
    for (int p = 0; p < 8; p++) begin
      drive(1'b1, 1'b0, DW'($urandom), 1'b0); step();
      drive(1'b1, 1'b1, DW'($urandom), 1'b0); step();
    end
    drive(1'b1, 1'b1, 24'h000444, 1'b0);
    for (int i = 0; i < NDROP; i++) step();
    checks++;
    if (o_drop_count !== exp_cnt() || o_overflow !== exp_ovf() || o_level !== LW'(16)) begin
      failures++;
      $display("FAIL stats_saturate: cnt=%h ovf=%b level=%0d required %h/%b/16",
               o_drop_count, o_overflow, o_level, exp_cnt(), exp_ovf());
    end
    i_clear_stats = 1'b1;
    step();
    i_clear_stats = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (o_drop_count !== 16'd0 || o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL stats_clear: cnt=%h ovf=%b required 0/0", o_drop_count, o_overflow);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_fill_and_pair_drop();
    test_level15();
    test_full_pop_right();
    test_random();
    test_reset_midstream();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
